data_mem_port: RTL and testbench
================================

Name: data_mem_port

Overview:
- Memory-stage responder for the control pipeline's data-memory request signals (access, write, mask type, extension type).
- Converts each mem-stage load/store into a single-outstanding req/ack bus transaction with byte enables.
- Extracts and extends load data.
- Stalls the pipeline (to hazard unit, drives exec->mem enable low) until the access completes.

Parameters:
- TIMEOUT, 255, max cycles in BUSY waiting for i_bus_ack before aborting with fault; >=1.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_en_access  in  1  mem-stage instruction accesses data memory
- i_en_write  in  1  1=store, 0=load (valid with i_en_access)
- i_mask_type  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_ext_type  in  1  load extension: 0 sign, 1 zero
- i_addr  in  32  byte address (ALU result)
- i_wdata  in  32  store data, right-aligned
- o_rdata  out  32  extended load result, registered
- o_stall  out  1  hold pipeline; hazard unit deasserts exec->mem enable
- o_misaligned  out  1  one-cycle pulse: misaligned access rejected
- o_fault  out  1  one-cycle pulse: bus timeout
- o_bus_req  out  1  bus request, registered, held until ack
- o_bus_we  out  1  bus write
- o_bus_addr  out  32  word-aligned address, {i_addr[31:2],2'b00}
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_ack  in  1  bus completes transaction this cycle
- i_bus_rdata  in  32  read word, valid with i_bus_ack on load

Behaviour:
- Reset (i_rst low, async):
  - State IDLE; timeout counter 0.
  - All registered outputs 0 immediately (o_rdata, o_bus_*, o_misaligned, o_fault).
  - o_stall forced 0 while i_rst low.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Aligned access (i_en_access=1, not misaligned):
    - o_stall=1 (combinational).
    - At the clock edge, latch we, mask, ext, addr[1:0], be, wdata, bus_addr; set o_bus_req=1; go BUSY.
  - Misaligned access (half with addr[0]=1; word/11 with addr[1:0]!=0):
    - No bus transaction; o_stall=0; o_misaligned=1 next cycle for one cycle; o_rdata unchanged; stay IDLE.
  - No access: o_stall=0.
- BUSY:
  - o_stall=1; o_bus_req=1; bus outputs stable.
  - On i_bus_ack: for loads, register extracted+extended i_bus_rdata into o_rdata; deassert o_bus_req at the edge; go DONE.
  - Counter increments each BUSY cycle without ack. On reaching TIMEOUT: deassert req; o_fault pulse; o_rdata=0 for loads; go DONE.
  - Ack in the same cycle the counter reaches TIMEOUT: ack wins, no fault.
- DONE:
  - o_stall=0 so the pipeline advances on this edge; go IDLE.
  - A new access is never started from DONE (inputs still belong to the finished instruction).
- Latency: zero-wait bus (ack in first BUSY cycle) gives 2 stall cycles. Each bus wait state adds 1.
- Store lanes:
  - byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
  - half: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}
  - word: be=4'b1111, wdata unchanged
- Load extract:
  - byte: rdata[8*addr[1:0]+:8]
  - half: rdata[16*addr[1]+:16]
  - word: full word
  - Extended to 32 bits per ext_type.
- Loads drive be per the same lane rules. Stores leave o_rdata unchanged.
- Input changes while BUSY are ignored (request latched).
- Reset mid-BUSY aborts the transaction: req drops asynchronously, no fault pulse.

Test Plan:
- Byte store addr=0x1003, wdata=0x000000AB, ack in first BUSY cycle -> bus_addr=0x1000, be=1000, bus_wdata=0xABABABAB, we=1; o_stall high exactly 2 cycles.
- Load byte addr=0x2001, ext=0, bus_rdata=0x1234_80FF, ack after 3 wait cycles -> o_rdata=0xFFFFFF80 in DONE; o_stall high 5 cycles. Same with ext=1 -> 0x00000080.
- Load half addr=0x2002, ext=0, rdata=0x8001_7FFF -> 0xFFFF8001. Word load addr=0x2000 -> 0x80017FFF, be=1111.
- Word load addr=0x3002 -> no o_bus_req, o_misaligned one-cycle pulse, o_stall=0, o_rdata unchanged.
- TIMEOUT=4, no ack -> req drops after 4 BUSY cycles, o_fault pulse, o_rdata=0, state returns IDLE after DONE. Ack coincident with the 4th cycle -> no fault.
- Assert i_rst low mid-BUSY -> o_bus_req=0 and o_stall=0 immediately. After release with no access -> IDLE, o_stall=0, o_rdata=0.

Source files
------------

// File: rtl/data_mem_port_if.sv
// Data-memory bus seen from the memory stage: single outstanding req/ack
// transaction with byte enables and a word-aligned address.
interface data_mem_port_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [BW-1:0] bus_be;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_mem_port.sv
// Memory-stage data port: turns a load/store into one req/ack bus transaction,
// stalls the pipeline until it completes, and extracts/extends load data.
module data_mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en_access,
  input  logic        i_en_write,
  input  logic [1:0]  i_mask_type,
  input  logic        i_ext_type,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_fault,
  data_mem_port_if.master bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  // Counter only needs to reach TIMEOUT-1; the last value is checked, not stored.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            ext_q, ext_d;
  logic [1:0]      mask_q, mask_d;
  logic [1:0]      off_q, off_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            fault_q, fault_d;

  logic            stall_c;
  logic            misaligned_c;
  logic [BW-1:0]   be_c;
  logic [DW-1:0]   wdata_c;
  logic [DW-1:0]   load_c;
  logic [7:0]      load_byte_c;
  logic [15:0]     load_half_c;

  // Half needs addr[0]==0; word (and the 11 encoding) needs addr[1:0]==0.
  assign misaligned_c = i_en_access &
                        (((i_mask_type == MASK_HALF) & i_addr[0]) |
                         (i_mask_type[1] & (i_addr[1:0] != 2'b00)));

  // Byte-lane placement of the store for the incoming request.
  always_comb begin : store_lanes
    be_c    = 4'b1111;
    wdata_c = i_wdata;
    case (i_mask_type)
      MASK_BYTE: begin
        be_c    = 4'b0001 << i_addr[1:0];
        wdata_c = {4{i_wdata[7:0]}};
      end
      MASK_HALF: begin
        be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin : load_extract
    load_byte_c = bus.bus_rdata[{off_q, 3'b000} +: 8];
    load_half_c = bus.bus_rdata[{off_q[1], 4'b0000} +: 16];
    load_c      = bus.bus_rdata;
    case (mask_q)
      MASK_BYTE: load_c = {{24{~ext_q & load_byte_c[7]}}, load_byte_c};
      MASK_HALF: load_c = {{16{~ext_q & load_half_c[15]}}, load_half_c};
      default:   load_c = bus.bus_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    ext_d   = ext_q;
    mask_d  = mask_q;
    off_d   = off_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    stall_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (misaligned_c) begin
          mis_d = 1'b1;
        end else if (i_en_access) begin
          stall_c = 1'b1;
          we_d    = i_en_write;
          ext_d   = i_ext_type;
          mask_d  = i_mask_type;
          off_d   = i_addr[1:0];
          be_d    = be_c;
          wdata_d = wdata_c;
          addr_d  = {i_addr[31:2], 2'b00};
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        stall_c = 1'b1;
        // An ack on the final allowed cycle still completes normally.
        if (bus.bus_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = load_c;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Inputs still describe the retiring instruction, so never restart here.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin : state_regs
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ext_q   <= 1'b0;
      mask_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ext_q   <= ext_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
    end
  end

  assign o_stall       = stall_c & i_rst;
  assign o_rdata       = rdata_q;
  assign o_misaligned  = mis_q;
  assign o_fault       = fault_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: directed test-plan cases plus random
// loads/stores against a transaction-level model of the memory-stage port.
module tb_data_mem_port;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_access, en_write, ext_type;
  logic [1:0]  mask_type;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misaligned, fault;

  data_mem_port_if bus_if ();

  data_mem_port #(.TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_en_access  (en_access),
    .i_en_write   (en_write),
    .i_mask_type  (mask_type),
    .i_ext_type   (ext_type),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .o_stall      (stall),
    .o_misaligned (misaligned),
    .o_fault      (fault),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic bit is_mis(input logic [1:0] m, input logic [31:0] a);
    if (m == 2'b00) return 1'b0;
    if (m == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] m, input logic [1:0] off);
    if (m == 2'b00) return 4'(32'd1 << off);
    if (m == 2'b01) return off[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] m, input logic [31:0] w);
    logic [31:0] b, h;
    b = w & 32'hFF;
    h = w & 32'hFFFF;
    if (m == 2'b00) return b * 32'h0101_0101;
    if (m == 2'b01) return h * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] m, input logic ext,
                                           input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    if (m == 2'b00) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!ext && v[7]) v = v | 32'hFFFF_FF00;
    end else if (m == 2'b01) begin
      v = (rd >> (off[1] ? 16 : 0)) & 32'hFFFF;
      if (!ext && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Present one access, act as the bus slave acking after `waits` wait cycles,
  // hold the instruction until the stall drops, then check the outcome.
  task automatic run_access(input logic we, input logic [1:0] m, input logic ext,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd,
                            input bit use_lit, input logic [31:0] lit_addr,
                            input logic [3:0] lit_be, input logic [31:0] lit_wd,
                            input logic [31:0] lit_rd, input int lit_stall);
    bit mis, tmo, done;
    int stalls, busy_n, exp_stalls, exp_busy;
    logic [31:0] exp_rd;

    mis        = is_mis(m, a);
    tmo        = !mis && (waits >= TO);
    exp_stalls = mis ? 0 : (tmo ? TO + 1 : waits + 2);
    exp_busy   = mis ? 0 : (tmo ? TO : waits + 1);
    if (mis || we) exp_rd = model_rdata;
    else if (tmo)  exp_rd = 32'h0;
    else           exp_rd = exp_load(m, ext, a[1:0], rd);

    @(posedge clk); #1;
    en_access = 1'b1; en_write = we; mask_type = m; ext_type = ext;
    addr = a; wdata = wd; bus_if.bus_rdata = rd;
    stalls = 0; busy_n = 0; done = 1'b0;

    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (bus_if.bus_req) begin
        busy_n++;
        chk("busy_stall", 32'(stall), 32'd1);
        chk("bus_addr", bus_if.bus_addr, {a[31:2], 2'b00});
        chk("bus_be", 32'(bus_if.bus_be), 32'(exp_be(m, a[1:0])));
        chk("bus_we", 32'(bus_if.bus_we), 32'(we));
        if (we) chk("bus_wdata", bus_if.bus_wdata, exp_wd(m, wd));
        if (use_lit) begin
          chk("lit_bus_addr", bus_if.bus_addr, lit_addr);
          chk("lit_bus_be", 32'(bus_if.bus_be), 32'(lit_be));
          if (we) chk("lit_bus_wdata", bus_if.bus_wdata, lit_wd);
        end
        bus_if.bus_ack = (busy_n == waits + 1);
      end else begin
        bus_if.bus_ack = 1'b0;
      end
      if (stall) stalls++;
      else done = 1'b1;
    end
    bus_if.bus_ack = 1'b0;

    chk("stall_bound", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    chk("misaligned_early", 32'(misaligned), 32'd0);
    if (!mis) begin
      chk("fault", 32'(fault), 32'(tmo));
      chk("rdata_done", rdata, exp_rd);
    end
    if (use_lit) begin
      chk("lit_stall", 32'(stalls), 32'(lit_stall));
      if (!mis) chk("lit_rdata", rdata, lit_rd);
    end

    @(posedge clk); #1;
    en_access = 1'b0;
    addr = $urandom; mask_type = 2'($urandom_range(0, 3));

    @(negedge clk);
    chk("misaligned_pulse", 32'(misaligned), 32'(mis));
    chk("fault_clear", 32'(fault), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_req", 32'(bus_if.bus_req), 32'd0);
    chk("rdata_hold", rdata, exp_rd);
    if (use_lit) chk("lit_rdata_hold", rdata, lit_rd);
    model_rdata = exp_rd;

    @(negedge clk);
    chk("misaligned_clear", 32'(misaligned), 32'd0);
  endtask

  initial begin
    en_access = 1'b0; en_write = 1'b0; ext_type = 1'b0; mask_type = 2'b00;
    addr = '0; wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    model_rdata = '0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases with hand-computed literals.
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0,
               1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 2);
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 3, 32'h1234_80FF,
               1'b1, 32'h0000_2000, 4'b0010, 32'h0, 32'hFFFF_FF80, 5);
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 3, 32'h1234_80FF,
               1'b1, 32'h0000_2000, 4'b0010, 32'h0, 32'h0000_0080, 5);
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 0, 32'h8001_7FFF,
               1'b1, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001, 2);
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0, 1, 32'h8001_7FFF,
               1'b1, 32'h0000_2000, 4'b1111, 32'h0, 32'h8001_7FFF, 3);
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 0, 32'h5555_5555,
               1'b1, 32'h0, 4'b0000, 32'h0, 32'h8001_7FFF, 0);
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 10, 32'hDEAD_BEEF,
               1'b1, 32'h0000_4000, 4'b1111, 32'h0, 32'h0, 5);
    run_access(1'b0, 2'b11, 1'b1, 32'h0000_4004, 32'h0, 3, 32'hCAFE_F00D,
               1'b1, 32'h0000_4004, 4'b1111, 32'h0, 32'hCAFE_F00D, 5);
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_5002, 32'h0000_1234, 9, 32'h0,
               1'b1, 32'h0000_5000, 4'b1100, 32'h1234_1234, 32'hCAFE_F00D, 5);

    // Reset while a transaction is outstanding.
    @(posedge clk); #1;
    en_access = 1'b1; en_write = 1'b0; mask_type = 2'b10; addr = 32'h0000_6000;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", 32'(bus_if.bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(bus_if.bus_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_fault", 32'(fault), 32'd0);
    en_access = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_stall", 32'(stall), 32'd0);
    chk("postrst_rdata", rdata, 32'h0);
    chk("postrst_req", 32'(bus_if.bus_req), 32'd0);
    chk("postrst_fault", 32'(fault), 32'd0);
    model_rdata = '0;

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'($urandom_range(0, 3)) & 2'b10;
      run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ra, $urandom,
                 int'($urandom_range(0, 5)), $urandom,
                 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
